mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit_pkg.sv | 64 ++++++
 rtl/mem_access_unit_if.sv | 14 +
 rtl/mem_access_unit_align.sv | 66 ++++++
 rtl/mem_access_unit.sv | 169 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants, decode and lane helpers for the MEM-stage data-memory access unit.
package mem_access_unit_pkg;

    localparam logic RstEnable = 1'b1;
    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;

    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_e;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} mau_state_e;

    typedef struct packed {
        logic      valid;
        logic      is_load;
        logic      is_signed;
        acc_size_e size;
    } acc_decode_t;

    function automatic acc_decode_t decode_op(input logic [7:0] op);
        acc_decode_t d;
        d = '{valid: 1'b0, is_load: 1'b0, is_signed: 1'b0, size: SZ_NONE};
        case (op)
            EXE_LB_OP:  d = '{valid: 1'b1, is_load: 1'b1, is_signed: 1'b1, size: SZ_BYTE};
            EXE_LBU_OP: d = '{valid: 1'b1, is_load: 1'b1, is_signed: 1'b0, size: SZ_BYTE};
            EXE_LH_OP:  d = '{valid: 1'b1, is_load: 1'b1, is_signed: 1'b1, size: SZ_HALF};
            EXE_LHU_OP: d = '{valid: 1'b1, is_load: 1'b1, is_signed: 1'b0, size: SZ_HALF};
            EXE_LW_OP:  d = '{valid: 1'b1, is_load: 1'b1, is_signed: 1'b0, size: SZ_WORD};
            EXE_SB_OP:  d = '{valid: 1'b1, is_load: 1'b0, is_signed: 1'b0, size: SZ_BYTE};
            EXE_SH_OP:  d = '{valid: 1'b1, is_load: 1'b0, is_signed: 1'b0, size: SZ_HALF};
            EXE_SW_OP:  d = '{valid: 1'b1, is_load: 1'b0, is_signed: 1'b0, size: SZ_WORD};
            default:    d = '{valid: 1'b0, is_load: 1'b0, is_signed: 1'b0, size: SZ_NONE};
        endcase
        return d;
    endfunction

    function automatic logic is_misaligned(input acc_size_e size, input logic [1:0] lo);
        logic m;
        case (size)
            SZ_HALF: m = lo[0];
            SZ_WORD: m = (lo != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Single-outstanding request/acknowledge data bus between the MEM stage and data memory.
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (output req, we, addr, sel, wdata, input ack, err, rdata);
    modport slave  (input req, we, addr, sel, wdata, output ack, err, rdata);
endinterface

// File: rtl/mem_access_unit_align.sv
// Big-endian byte-lane steering: byte enables and store replication for issue,
// lane extraction with sign/zero extension for returned read data.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  acc_size_e   size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [3:0]  ld_sel,
    input  logic        ld_signed,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] ld_value
);

    // Byte enables and lane-replicated store data for the access being issued
    always_comb begin
        sel   = 4'b0000;
        wdata = 32'h0000_0000;
        case (size)
            SZ_BYTE: begin
                wdata = {4{store_data[7:0]}};
                case (addr_lo)
                    2'b00:   sel = 4'b1000;
                    2'b01:   sel = 4'b0100;
                    2'b10:   sel = 4'b0010;
                    2'b11:   sel = 4'b0001;
                    default: sel = 4'b0000;
                endcase
            end
            SZ_HALF: begin
                wdata = {2{store_data[15:0]}};
                if (addr_lo[1]) begin
                    sel = 4'b0011;
                end else begin
                    sel = 4'b1100;
                end
            end
            SZ_WORD: begin
                sel   = 4'b1111;
                wdata = store_data;
            end
            default: begin
                sel   = 4'b0000;
                wdata = 32'h0000_0000;
            end
        endcase
    end

    // Lane extraction of returned read data, steered by the latched byte enables
    always_comb begin
        ld_value = 32'h0000_0000;
        case (ld_sel)
            4'b1000: ld_value = ext_byte(rdata[31:24], ld_signed);
            4'b0100: ld_value = ext_byte(rdata[23:16], ld_signed);
            4'b0010: ld_value = ext_byte(rdata[15:8],  ld_signed);
            4'b0001: ld_value = ext_byte(rdata[7:0],   ld_signed);
            4'b1100: ld_value = ext_half(rdata[31:16], ld_signed);
            4'b0011: ld_value = ext_half(rdata[15:0],  ld_signed);
            4'b1111: ld_value = rdata;
            default: ld_value = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues one bus transaction per load/store,
// stalls the pipeline until it completes, and handles flush, bus error and timeout.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         stall,
    input  logic               flush,
    input  logic [7:0]         mem_aluop,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_reg2,
    output logic [31:0]        load_data,
    output logic               load_valid,
    output logic               stallreq,
    output logic               adel,
    output logic               ades,
    output logic               bus_err,
    mem_access_unit_if.master  bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    mau_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             req_r;
    logic             we_r;
    logic [31:0]      addr_r;
    logic [3:0]       sel_r;
    logic [31:0]      wdata_r;
    logic [31:0]      load_data_r;
    logic             load_valid_r;
    logic             bus_err_r;
    logic             ld_signed_r;
    logic             ld_is_load_r;

    acc_decode_t      dec_s;
    logic             misaligned_s;
    logic             issue_s;
    logic [3:0]       sel_s;
    logic [31:0]      wdata_s;
    logic [31:0]      ld_value_s;
    logic             unused_stall_s;

    assign dec_s          = decode_op(mem_aluop);
    assign misaligned_s   = dec_s.valid & is_misaligned(dec_s.size, mem_addr[1:0]);
    assign issue_s        = (state_r == ST_IDLE) & dec_s.valid & ~misaligned_s & ~flush;
    assign unused_stall_s = ^{stall[5], stall[3:0]};

    mem_lane_align u_align (
        .size       (dec_s.size),
        .addr_lo    (mem_addr[1:0]),
        .store_data (mem_reg2),
        .ld_sel     (sel_r),
        .ld_signed  (ld_signed_r),
        .rdata      (bus.rdata),
        .sel        (sel_s),
        .wdata      (wdata_s),
        .ld_value   (ld_value_s)
    );

    // Stall request and address-error flags depend on the op currently presented
    always_comb begin
        stallreq = 1'b0;
        adel     = 1'b0;
        ades     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stallreq = issue_s;
                adel     = misaligned_s & dec_s.is_load;
                ades     = misaligned_s & ~dec_s.is_load;
            end
            ST_BUSY: stallreq = 1'b1;
            ST_DONE: stallreq = 1'b0;
            default: stallreq = 1'b0;
        endcase
    end

    // Transaction FSM, timeout counter and all registered outputs
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            req_r        <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= 32'h0000_0000;
            sel_r        <= 4'b0000;
            wdata_r      <= 32'h0000_0000;
            load_data_r  <= 32'h0000_0000;
            load_valid_r <= 1'b0;
            bus_err_r    <= 1'b0;
            ld_signed_r  <= 1'b0;
            ld_is_load_r <= 1'b0;
        end else begin
            bus_err_r <= 1'b0;
            if (flush) begin
                // A flush wins over any bus response arriving in the same cycle
                state_r      <= ST_IDLE;
                cnt_r        <= '0;
                req_r        <= 1'b0;
                load_valid_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (issue_s) begin
                            req_r        <= 1'b1;
                            we_r         <= ~dec_s.is_load;
                            addr_r       <= {mem_addr[31:2], 2'b00};
                            sel_r        <= sel_s;
                            wdata_r      <= wdata_s;
                            ld_signed_r  <= dec_s.is_signed;
                            ld_is_load_r <= dec_s.is_load;
                            cnt_r        <= '0;
                            state_r      <= ST_BUSY;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_BUSY: begin
                        if (bus.err || (cnt_r == TIMEOUT_LAST)) begin
                            req_r        <= 1'b0;
                            load_data_r  <= 32'h0000_0000;
                            load_valid_r <= ld_is_load_r;
                            bus_err_r    <= 1'b1;
                            cnt_r        <= '0;
                            state_r      <= ST_DONE;
                        end else if (bus.ack) begin
                            req_r        <= 1'b0;
                            load_data_r  <= ld_is_load_r ? ld_value_s : load_data_r;
                            load_valid_r <= ld_is_load_r;
                            cnt_r        <= '0;
                            state_r      <= ST_DONE;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    ST_DONE: begin
                        if (stall[4] == NoStop) begin
                            load_valid_r <= 1'b0;
                            state_r      <= ST_IDLE;
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end
                    default: begin
                        state_r      <= ST_IDLE;
                        req_r        <= 1'b0;
                        load_valid_r <= 1'b0;
                        cnt_r        <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.req    = req_r;
    assign bus.we     = we_r;
    assign bus.addr   = addr_r;
    assign bus.sel    = sel_r;
    assign bus.wdata  = wdata_r;
    assign load_data  = load_data_r;
    assign load_valid = load_valid_r;
    assign bus_err    = bus_err_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// loads/stores checked against an arithmetic byte-lane reference model.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_addr;
    logic [31:0] mem_reg2;
    logic [31:0] load_data;
    logic        load_valid;
    logic        stallreq;
    logic        adel;
    logic        ades;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] op_code   [8];
    int         op_bytes  [8];
    bit         op_load   [8];
    bit         op_signed [8];

    mem_access_unit_if bus_if ();

    mem_access_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .mem_aluop  (mem_aluop),
        .mem_addr   (mem_addr),
        .mem_reg2   (mem_reg2),
        .load_data  (load_data),
        .load_valid (load_valid),
        .stallreq   (stallreq),
        .adel       (adel),
        .ades       (ades),
        .bus_err    (bus_err),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One complete access: present op, answer the bus after `delay` BUSY cycles,
    // optionally hold DONE with stall[4], then retire the op.
    task automatic run_access(input string tag, input int k, input logic [31:0] addr,
                              input logic [31:0] reg2, input logic [31:0] rdata,
                              input int delay, input bit use_err, input int hold);
        int          n, off, sh, stall_cnt;
        bit          ld, mis;
        logic [3:0]  e_sel;
        logic [31:0] e_wdata, e_load, mask;
        n   = op_bytes[k];
        ld  = op_load[k];
        off = int'(addr % 32'd4);
        mis = (addr % n) != 0;
        e_sel = 4'b0000;
        e_load = 32'h0;
        if (!mis) begin
            e_sel = 4'((((1 << n) - 1) << (4 - n - off)));
            sh    = 8 * (4 - n - off);
            mask  = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
            e_load = (rdata >> sh) & mask;
            if (op_signed[k] && n < 4 && e_load[8 * n - 1]) e_load = e_load | ~mask;
        end
        if (use_err) e_load = 32'h0;
        e_wdata = 32'h0;
        for (int i = 0; i < 4; i++) e_wdata[8 * i +: 8] = reg2[8 * (i % n) +: 8];

        @(negedge clk);
        mem_aluop = op_code[k]; mem_addr = addr; mem_reg2 = reg2; stall = 6'b000000;
        bus_if.rdata = rdata;
        #1;
        check({tag, "_adel"}, {31'b0, adel}, {31'b0, ld & mis});
        check({tag, "_ades"}, {31'b0, ades}, {31'b0, ~ld & mis});
        check({tag, "_stall0"}, {31'b0, stallreq}, {31'b0, ~mis});
        if (mis) begin
            @(negedge clk);
            check({tag, "_misreq"}, {31'b0, bus_if.req}, 32'h0);
            check({tag, "_misstall"}, {31'b0, stallreq}, 32'h0);
            mem_aluop = EXE_NOP_OP;
            return;
        end
        stall_cnt = 1;
        @(negedge clk);
        check({tag, "_req"}, {31'b0, bus_if.req}, 32'h1);
        check({tag, "_we"}, {31'b0, bus_if.we}, {31'b0, ~ld});
        check({tag, "_addr"}, bus_if.addr, {addr[31:2], 2'b00});
        check({tag, "_sel"}, {28'b0, bus_if.sel}, {28'b0, e_sel});
        if (!ld) check({tag, "_wdata"}, bus_if.wdata, e_wdata);
        for (int c = 0; c < delay; c++) begin
            if (stallreq) stall_cnt++;
            @(negedge clk);
        end
        if (stallreq) stall_cnt++;
        bus_if.ack = use_err ? 1'($urandom_range(0, 1)) : 1'b1;
        bus_if.err = use_err;
        @(negedge clk);
        bus_if.ack = 1'b0; bus_if.err = 1'b0;
        check({tag, "_stallcycles"}, stall_cnt, 2 + delay);
        check({tag, "_donereq"}, {31'b0, bus_if.req}, 32'h0);
        check({tag, "_donestall"}, {31'b0, stallreq}, 32'h0);
        check({tag, "_buserr"}, {31'b0, bus_err}, {31'b0, use_err});
        check({tag, "_lvalid"}, {31'b0, load_valid}, {31'b0, ld});
        if (ld) check({tag, "_ldata"}, load_data, e_load);
        for (int h = 0; h < hold; h++) begin
            stall = 6'b010000;
            @(negedge clk);
            check({tag, "_holdreq"}, {31'b0, bus_if.req}, 32'h0);
            check({tag, "_holdlv"}, {31'b0, load_valid}, {31'b0, ld});
            check({tag, "_holderr"}, {31'b0, bus_err}, 32'h0);
        end
        stall = 6'b000000;
        mem_aluop = EXE_NOP_OP;
        @(negedge clk);
        check({tag, "_retlv"}, {31'b0, load_valid}, 32'h0);
        check({tag, "_reterr"}, {31'b0, bus_err}, 32'h0);
        check({tag, "_retstall"}, {31'b0, stallreq}, 32'h0);
    endtask

    initial begin
        int req_cnt, k, n;
        logic [31:0] a;
        op_code = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
        op_bytes  = '{1, 1, 2, 2, 4, 1, 2, 4};
        op_load   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        op_signed = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; stall = 6'b0; flush = 1'b0; mem_aluop = EXE_NOP_OP;
        mem_addr = 32'h0; mem_reg2 = 32'h0;
        bus_if.ack = 1'b0; bus_if.err = 1'b0; bus_if.rdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_req", {31'b0, bus_if.req}, 32'h0);
        check("rst_ldata", load_data, 32'h0);
        check("rst_lvalid", {31'b0, load_valid}, 32'h0);
        check("rst_stall", {31'b0, stallreq}, 32'h0);
        check("rst_buserr", {31'b0, bus_err}, 32'h0);
        check("rst_sel", {28'b0, bus_if.sel}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed scenarios
        run_access("lw", 4, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 0);
        check("lw_const", load_data, 32'hDEAD_BEEF);
        check("lw_selconst", {28'b0, bus_if.sel}, 32'h0000_000F);
        run_access("lb", 0, 32'h0000_0103, 32'h0, 32'h0000_00F0, 0, 1'b0, 0);
        check("lb_const", load_data, 32'hFFFF_FFF0);
        check("lb_selconst", {28'b0, bus_if.sel}, 32'h0000_0001);
        run_access("lbu", 1, 32'h0000_0103, 32'h0, 32'h0000_00F0, 0, 1'b0, 0);
        check("lbu_const", load_data, 32'h0000_00F0);
        run_access("sh", 6, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 1, 1'b0, 0);
        check("sh_wconst", bus_if.wdata, 32'hABCD_ABCD);
        check("sh_selconst", {28'b0, bus_if.sel}, 32'h0000_0003);
        run_access("lwmis", 4, 32'h0000_0101, 32'h0, 32'h0, 0, 1'b0, 0);
        run_access("shmis", 6, 32'h0000_0203, 32'h0, 32'h0, 0, 1'b0, 0);
        run_access("lhhold", 2, 32'h0000_0302, 32'h0, 32'h1234_8001, 2, 1'b0, 2);

        // Ack/err outside BUSY are ignored
        @(negedge clk);
        bus_if.ack = 1'b1; bus_if.err = 1'b1;
        @(negedge clk);
        bus_if.ack = 1'b0; bus_if.err = 1'b0;
        check("idleack_lv", {31'b0, load_valid}, 32'h0);
        check("idleack_err", {31'b0, bus_err}, 32'h0);

        // Timeout with no response
        @(negedge clk);
        mem_aluop = EXE_LW_OP; mem_addr = 32'h0000_0300;
        req_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus_err) break;
            if (bus_if.req) req_cnt++;
        end
        check("to_reqcycles", req_cnt, 255);
        check("to_buserr", {31'b0, bus_err}, 32'h1);
        check("to_req", {31'b0, bus_if.req}, 32'h0);
        check("to_ldata", load_data, 32'h0);
        check("to_stall", {31'b0, stallreq}, 32'h0);
        mem_aluop = EXE_NOP_OP;
        @(negedge clk);
        check("to_pulse", {31'b0, bus_err}, 32'h0);

        // Flush in the same cycle as ack
        mem_aluop = EXE_LW_OP; mem_addr = 32'h0000_0400; bus_if.rdata = 32'h5555_AAAA;
        @(negedge clk);
        bus_if.ack = 1'b1; flush = 1'b1;
        @(negedge clk);
        bus_if.ack = 1'b0; flush = 1'b0; mem_aluop = EXE_NOP_OP;
        #1;
        check("fl_lv", {31'b0, load_valid}, 32'h0);
        check("fl_err", {31'b0, bus_err}, 32'h0);
        check("fl_req", {31'b0, bus_if.req}, 32'h0);
        check("fl_stall", {31'b0, stallreq}, 32'h0);
        run_access("postfl", 4, 32'h0000_0404, 32'h0, 32'h0BAD_F00D, 0, 1'b0, 0);

        // Reset mid-transaction
        @(negedge clk);
        mem_aluop = EXE_LW_OP; mem_addr = 32'h0000_0500;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_aluop = EXE_NOP_OP;
        check("rstmid_req", {31'b0, bus_if.req}, 32'h0);
        check("rstmid_ldata", load_data, 32'h0);
        check("rstmid_err", {31'b0, bus_err}, 32'h0);

        // Randomized loads/stores
        for (int it = 0; it < 80; it++) begin
            k = int'($urandom_range(0, 7));
            n = op_bytes[k];
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(n) - 32'd1);
            run_access("rnd", k, a, $urandom, $urandom, int'($urandom_range(0, 3)),
                       ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
